// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the three-requester memory arbiter.
package mem_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int NREQ = 3;

  localparam int REQ_IF   = 0;
  localparam int REQ_DATA = 1;
  localparam int REQ_DBG  = 2;

  // Encoding of the round-robin last_served bit.
  localparam logic LS_IF   = 1'b0;
  localparam logic LS_DATA = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic [XLEN-1:0] onehot_mux(
    input logic [NREQ-1:0]           sel,
    input logic [NREQ-1:0][XLEN-1:0] din
  );
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) r = r | din[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection: debug first, then round-robin between ifetch and data.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] m_req,
  input  logic            last_served,
  output logic [NREQ-1:0] winner
);

  always_comb begin
    winner = '0;
    if (m_req[REQ_DBG]) begin
      winner[REQ_DBG] = 1'b1;
    end else if (m_req[REQ_IF] && m_req[REQ_DATA]) begin
      if (last_served == LS_DATA) winner[REQ_IF]   = 1'b1;
      else                        winner[REQ_DATA] = 1'b1;
    end else if (m_req[REQ_IF]) begin
      winner[REQ_IF] = 1'b1;
    end else if (m_req[REQ_DATA]) begin
      winner[REQ_DATA] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter for ifetch, data and debug requesters,
// with a BUSY-cycle timeout that forces an error completion.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           m_req,
  input  logic [NREQ-1:0]           m_we,
  input  logic [NREQ-1:0][XLEN-1:0] m_addr,
  input  logic [NREQ-1:0][XLEN-1:0] m_wdata,
  output logic [NREQ-1:0]           m_mfc,
  output logic [XLEN-1:0]           m_rdata,
  output logic                      m_err,
  output logic [NREQ-1:0]           gnt,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [XLEN-1:0]           mem_addr,
  output logic [XLEN-1:0]           mem_wdata,
  input  logic [XLEN-1:0]           mem_rdata,
  input  logic                      mem_mfc
);

  // Completion fires on the edge where the counter would reach TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [NREQ-1:0]       m_mfc_q, m_mfc_d;
  logic                  m_err_q, m_err_d;
  logic [XLEN-1:0]       m_rdata_q, m_rdata_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [XLEN-1:0]       mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;
  logic [7:0]            tmo_q, tmo_d;
  logic                  last_served_q, last_served_d;

  logic [NREQ-1:0]       winner;
  logic                  win_we;
  logic [XLEN-1:0]       win_addr;
  logic [XLEN-1:0]       win_wdata;
  logic                  done;

  arb_pick u_pick (
    .m_req       (m_req),
    .last_served (last_served_q),
    .winner      (winner)
  );

  assign win_we    = |(m_we & winner);
  assign win_addr  = onehot_mux(winner, m_addr);
  assign win_wdata = onehot_mux(winner, m_wdata);

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    m_mfc_d       = '0;
    m_err_d       = 1'b0;
    m_rdata_d     = m_rdata_q;
    mem_rd_d      = mem_rd_q;
    mem_wr_d      = mem_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    tmo_d         = tmo_q;
    last_served_d = last_served_q;
    done          = 1'b0;

    case (state_q)
      IDLE: begin
        if (|m_req) begin
          state_d     = BUSY;
          gnt_d       = winner;
          mem_rd_d    = ~win_we;
          mem_wr_d    = win_we;
          mem_addr_d  = win_addr;
          mem_wdata_d = win_wdata;
          tmo_d       = '0;
        end
      end
      BUSY: begin
        // A real completion takes precedence over a coincident timeout.
        if (mem_mfc) begin
          done      = 1'b1;
          m_rdata_d = mem_rdata;
        end else if (tmo_q == TMO_LAST) begin
          done      = 1'b1;
          m_err_d   = 1'b1;
          m_rdata_d = '0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end

        if (done) begin
          state_d  = IDLE;
          m_mfc_d  = gnt_q;
          gnt_d    = '0;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          tmo_d    = '0;
          if (gnt_q[REQ_IF])        last_served_d = LS_IF;
          else if (gnt_q[REQ_DATA]) last_served_d = LS_DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      m_mfc_q       <= '0;
      m_err_q       <= 1'b0;
      m_rdata_q     <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      tmo_q         <= '0;
      last_served_q <= LS_DATA;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      m_mfc_q       <= m_mfc_d;
      m_err_q       <= m_err_d;
      m_rdata_q     <= m_rdata_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      tmo_q         <= tmo_d;
      last_served_q <= last_served_d;
    end
  end

  assign gnt       = gnt_q;
  assign m_mfc     = m_mfc_q;
  assign m_err     = m_err_q;
  assign m_rdata   = m_rdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences, randomized transactions.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TMO = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          m_req, m_we;
  logic [2:0][31:0]    m_addr, m_wdata;
  logic [2:0]          m_mfc;
  logic [31:0]         m_rdata;
  logic                m_err;
  logic [2:0]          gnt;
  logic                mem_rd, mem_wr;
  logic [31:0]         mem_addr, mem_wdata;
  logic [31:0]         mem_rdata;
  logic                mem_mfc;

  int n_tests = 0;
  int n_fail  = 0;
  logic model_last;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_mfc     (m_mfc),
    .m_rdata   (m_rdata),
    .m_err     (m_err),
    .gnt       (gnt),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_mfc   (mem_mfc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    int          lat;
    bit          scr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdv;
    logic [2:0]  gnt;
    bit          err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; lat = BUSY cycle in which memory answers (0 = never).
  task automatic run_txn(input string name, input logic [2:0] req, input logic [2:0] we,
                         input int lat, input bit scr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdv,
                         input logic [2:0] exp_gnt, input bit exp_err);
    int   done_c;
    logic exp_we;
    done_c = (lat >= 1 && lat <= TMO) ? lat : TMO;
    exp_we = |(we & exp_gnt);
    m_req  = req;
    m_we   = we;
    for (int i = 0; i < 3; i++) begin
      if (exp_gnt[i]) begin
        m_addr[i]  = addr;
        m_wdata[i] = wdata;
      end else begin
        m_addr[i]  = $urandom;
        m_wdata[i] = $urandom;
      end
    end
    mem_mfc = 1'b0;
    tick();
    chk({name, " gnt"},       32'(gnt),       32'(exp_gnt));
    chk({name, " mem_rd"},    32'(mem_rd),    32'(!exp_we));
    chk({name, " mem_wr"},    32'(mem_wr),    32'(exp_we));
    chk({name, " mem_addr"},  mem_addr,       addr);
    chk({name, " mem_wdata"}, mem_wdata,      wdata);
    chk({name, " m_mfc_idle"}, 32'(m_mfc),    32'd0);
    for (int c = 1; c <= TMO; c++) begin
      if (scr) begin
        m_req = 3'($urandom);
        m_we  = 3'($urandom);
        for (int i = 0; i < 3; i++) begin
          m_addr[i]  = $urandom;
          m_wdata[i] = $urandom;
        end
      end
      mem_mfc   = (c == lat);
      mem_rdata = (c == lat) ? rdv : $urandom;
      tick();
      mem_mfc = 1'b0;
      if (c == done_c) begin
        chk({name, " m_mfc"}, 32'(m_mfc), 32'(exp_gnt));
        chk({name, " m_err"}, 32'(m_err), 32'(exp_err));
        if (!exp_err || !exp_we)
          chk({name, " m_rdata"}, m_rdata, exp_err ? 32'd0 : rdv);
        chk({name, " gnt_clr"}, 32'(gnt), 32'd0);
        chk({name, " strobes_clr"}, 32'({mem_rd, mem_wr}), 32'd0);
        break;
      end else begin
        chk({name, " hold_strobe"}, 32'({mem_rd, mem_wr}), 32'({!exp_we, exp_we}));
        chk({name, " hold_addr"},   mem_addr, addr);
        chk({name, " no_early_mfc"}, 32'(m_mfc), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    mem_rdata = '0; mem_mfc = 1'b0;
    tick();
    tick();
    chk("rst gnt",       32'(gnt),  32'd0);
    chk("rst strobes",   32'({mem_rd, mem_wr}), 32'd0);
    chk("rst mem_addr",  mem_addr,  32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst m_mfc",     32'(m_mfc), 32'd0);
    chk("rst m_rdata",   m_rdata,   32'd0);
    chk("rst m_err",     32'(m_err), 32'd0);
    rst = 1'b0;

    tbl[0] = '{3'b001, 3'b000, 3, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 3'b001, 1'b0};
    tbl[1] = '{3'b011, 3'b000, 1, 1'b0, 32'h0000_0020, 32'h0,         32'h1111_1111, 3'b010, 1'b0};
    tbl[2] = '{3'b011, 3'b000, 1, 1'b0, 32'h0000_0030, 32'h0,         32'h2222_2222, 3'b001, 1'b0};
    tbl[3] = '{3'b011, 3'b000, 1, 1'b0, 32'h0000_0040, 32'h0,         32'h3333_3333, 3'b010, 1'b0};
    tbl[4] = '{3'b111, 3'b100, 2, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h4444_4444, 3'b100, 1'b0};
    tbl[5] = '{3'b011, 3'b011, 1, 1'b1, 32'h0000_0050, 32'hA5A5_A5A5, 32'h5555_5555, 3'b001, 1'b0};
    tbl[6] = '{3'b010, 3'b000, 0, 1'b1, 32'h0000_0060, 32'h0,         32'h6666_6666, 3'b010, 1'b1};
    tbl[7] = '{3'b011, 3'b010, 4, 1'b0, 32'h0000_0070, 32'h0,         32'h7777_7777, 3'b001, 1'b0};
    tbl[8] = '{3'b001, 3'b000, 2, 1'b0, 32'h0000_0080, 32'h0,         32'h8888_8888, 3'b001, 1'b0};
    tbl[9] = '{3'b011, 3'b001, 2, 1'b0, 32'h0000_0090, 32'h0,         32'h9999_9999, 3'b010, 1'b0};

    for (int v = 0; v < 10; v++) begin
      run_txn($sformatf("tbl%0d", v), tbl[v].req, tbl[v].we, tbl[v].lat, tbl[v].scr,
              tbl[v].addr, tbl[v].wdata, tbl[v].rdv, tbl[v].gnt, tbl[v].err);
    end
    m_req = '0;

    // Memory completion while idle must not produce a pulse.
    mem_mfc = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    chk("idle_mfc m_mfc", 32'(m_mfc), 32'd0);
    chk("idle_mfc gnt",   32'(gnt),   32'd0);
    tick();
    chk("idle_mfc m_mfc2", 32'(m_mfc), 32'd0);
    mem_mfc = 1'b0;
    tick();

    // Reset in the second BUSY cycle of a data write.
    m_req = 3'b010; m_we = 3'b010; m_addr[1] = 32'h200; m_wdata[1] = 32'h55AA_55AA;
    tick();
    chk("midrst gnt", 32'(gnt), 32'b010);
    chk("midrst wr",  32'(mem_wr), 32'd1);
    m_req = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst gnt0",   32'(gnt),    32'd0);
    chk("midrst wr0",    32'(mem_wr), 32'd0);
    chk("midrst mfc0",   32'(m_mfc),  32'd0);
    chk("midrst addr0",  mem_addr,    32'd0);
    chk("midrst wdata0", mem_wdata,   32'd0);
    tick();
    chk("midrst mfc_after", 32'(m_mfc), 32'd0);
    chk("midrst idle",      32'(gnt),   32'd0);
    run_txn("post_rst", 3'b011, 3'b000, 2, 1'b0, 32'h300, 32'h0, 32'h0BAD_F00D, 3'b001, 1'b0);
    m_req = '0;

    // Randomized transactions against a rule-level model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_last = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  req, we, eg;
      int          lat, w;
      bit          scr, err;
      logic [31:0] a, d, r;
      req = 3'($urandom_range(1, 7));
      we  = 3'($urandom);
      lat = $urandom_range(0, 6);
      scr = 1'($urandom);
      a   = $urandom;
      d   = $urandom;
      r   = $urandom;
      if (req[2])               w = 2;
      else if (req[0] && req[1]) w = model_last ? 0 : 1;
      else if (req[0])          w = 0;
      else                      w = 1;
      eg  = 3'b001 << w;
      err = !(lat >= 1 && lat <= TMO);
      run_txn($sformatf("rnd%0d", n), req, we, lat, scr, a, d, r, eg, err);
      if (w != 2) model_last = (w == 1);
    end
    m_req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
